// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder: a word-addressed RAM behind a
// valid/ready request channel with a fixed, parameterised response latency.
module data_mem_responder #(
  parameter int N       = 32,
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic [3:0]     cnt_r;
  logic [3:0]     cnt_next_s;
  logic           accept_s;
  logic           enter_resp_s;
  logic           handshake_s;

  logic           cap_write_r;
  logic [31:0]    cap_addr_r;
  logic [N-1:0]   cap_wdata_r;

  logic           sel_write_s;
  logic [31:0]    sel_addr_s;
  logic [N-1:0]   sel_wdata_s;
  logic [31:0]    sel_index_s;
  logic [AW-1:0]  sel_idx_s;
  logic           sel_err_s;

  logic           req_ready_r;
  logic           resp_valid_r;
  logic           resp_err_r;
  logic [N-1:0]   resp_rdata_r;

  logic [N-1:0]   mem_r [DEPTH] = '{default: '0};

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

  // With LATENCY=1 the access happens on the accepting edge, before capture, so IDLE uses the live inputs
  always_comb begin
    if (state_r == IDLE) begin
      sel_write_s = req_write;
      sel_addr_s  = req_addr;
      sel_wdata_s = req_wdata;
    end else begin
      sel_write_s = cap_write_r;
      sel_addr_s  = cap_addr_r;
      sel_wdata_s = cap_wdata_r;
    end
    sel_index_s = {2'b00, sel_addr_s[31:2]};
    sel_idx_s   = sel_addr_s[AW+1:2];
    sel_err_s   = (sel_addr_s[1:0] != 2'b00) || (sel_index_s >= DEPTH_W);
  end

  // Next-state and latency counter
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    enter_resp_s = 1'b0;
    handshake_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (LATENCY == 1) begin
            state_next_s = RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_next_s = WAIT;
            cnt_next_s   = CNT_LOAD;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd1) begin
          state_next_s = RESP;
          cnt_next_s   = 4'd0;
          enter_resp_s = 1'b1;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next_s = IDLE;
          handshake_s  = 1'b1;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // State register and counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Request capture at acceptance
  always_ff @(posedge clock) begin
    if (reset) begin
      cap_write_r <= 1'b0;
      cap_addr_r  <= 32'd0;
      cap_wdata_r <= '0;
    end else if (accept_s) begin
      cap_write_r <= req_write;
      cap_addr_r  <= req_addr;
      cap_wdata_r <= req_wdata;
    end
  end

  // Storage array; no reset so contents survive it, and reset suppresses a pending store
  always_ff @(posedge clock) begin
    if (!reset && enter_resp_s && sel_write_s && !sel_err_s) begin
      mem_r[sel_idx_s] <= sel_wdata_s;
    end
  end

  // Registered handshake and response outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= '0;
      resp_err_r   <= 1'b0;
    end else begin
      req_ready_r  <= (state_next_s == IDLE);
      resp_valid_r <= (state_next_s == RESP);
      if (enter_resp_s) begin
        resp_err_r   <= sel_err_s;
        resp_rdata_r <= (!sel_write_s && !sel_err_s) ? mem_r[sel_idx_s] : '0;
      end else if (handshake_s) begin
        resp_err_r   <= 1'b0;
        resp_rdata_r <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances at LATENCY 2, 3 and 1
// sharing one clock and reset.
module tb_data_mem_responder;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic        a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic        c_req_valid, c_req_ready, c_req_write, c_resp_valid, c_resp_err;
  logic [31:0] c_req_addr, c_req_wdata, c_resp_rdata;

  data_mem_responder #(.N(32), .DEPTH(32), .LATENCY(2)) u_lat2 (
    .clock(clock), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  data_mem_responder #(.N(32), .DEPTH(32), .LATENCY(3)) u_lat3 (
    .clock(clock), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  data_mem_responder #(.N(32), .DEPTH(32), .LATENCY(1)) u_lat1 (
    .clock(clock), .reset(reset),
    .req_valid(c_req_valid), .req_ready(c_req_ready), .req_write(c_req_write),
    .req_addr(c_req_addr), .req_wdata(c_req_wdata),
    .resp_valid(c_resp_valid), .resp_ready(1'b1),
    .resp_rdata(c_resp_rdata), .resp_err(c_resp_err)
  );

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // LATENCY=2 transaction; hold = cycles resp_ready stays low after resp_valid rises
  task automatic a_txn(input string name, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int hold);
    a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wdata;
    n_tests++;
    if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL %s idle_ready: got %b want 1", name, a_req_ready); end
    step;
    // noise while busy: must be neither queued nor captured
    a_req_write = 1'b1; a_req_addr = 32'h0000_0000; a_req_wdata = 32'hDEAD_BEEF;
    n_tests++;
    if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s wait_cycle: valid=%b ready=%b want 0 0", name, a_resp_valid, a_req_ready);
    end
    step;
    a_req_valid = 1'b0;
    n_tests++;
    if (a_resp_valid !== 1'b1 || a_resp_rdata !== exp_rdata || a_resp_err !== exp_err || a_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s resp: valid=%b rdata=%h err=%b ready=%b want 1 %h %b 0",
                         name, a_resp_valid, a_resp_rdata, a_resp_err, a_req_ready, exp_rdata, exp_err);
    end
    for (int i = 0; i < hold; i++) begin
      step;
      n_tests++;
      if (a_resp_valid !== 1'b1 || a_resp_rdata !== exp_rdata || a_resp_err !== exp_err || a_req_ready !== 1'b0) begin
        n_fail++; $display("FAIL %s hold%0d: valid=%b rdata=%h err=%b ready=%b want 1 %h %b 0",
                           name, i, a_resp_valid, a_resp_rdata, a_resp_err, a_req_ready, exp_rdata, exp_err);
      end
    end
    a_resp_ready = 1'b1;
    step;
    a_resp_ready = 1'b0;
    n_tests++;
    if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s after_handshake: valid=%b ready=%b want 0 1", name, a_resp_valid, a_req_ready);
    end
  endtask

  // LATENCY=3 transaction: resp_valid first visible after the third edge
  task automatic b_txn(input string name, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr; b_req_wdata = wdata;
    step;
    b_req_valid = 1'b0; b_req_addr = 32'h0000_0003;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (b_resp_valid !== 1'b0) begin n_fail++; $display("FAIL %s early_valid%0d: got %b want 0", name, i, b_resp_valid); end
      step;
    end
    n_tests++;
    if (b_resp_valid !== 1'b1 || b_resp_rdata !== exp_rdata || b_resp_err !== exp_err) begin
      n_fail++; $display("FAIL %s resp: valid=%b rdata=%h err=%b want 1 %h %b",
                         name, b_resp_valid, b_resp_rdata, b_resp_err, exp_rdata, exp_err);
    end
    b_resp_ready = 1'b1;
    step;
    b_resp_ready = 1'b0;
    n_tests++;
    if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s after_handshake: valid=%b ready=%b want 0 1", name, b_resp_valid, b_req_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step;
    step;
    n_tests++;
    if ({a_req_ready, a_resp_valid, a_resp_rdata, a_resp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL reset_lat2: ready=%b valid=%b rdata=%h err=%b want 1 0 0 0", a_req_ready, a_resp_valid, a_resp_rdata, a_resp_err);
    end
    n_tests++;
    if ({b_req_ready, b_resp_valid, b_resp_rdata, b_resp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL reset_lat3: ready=%b valid=%b rdata=%h err=%b want 1 0 0 0", b_req_ready, b_resp_valid, b_resp_rdata, b_resp_err);
    end
    n_tests++;
    if ({c_req_ready, c_resp_valid, c_resp_rdata, c_resp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL reset_lat1: ready=%b valid=%b rdata=%h err=%b want 1 0 0 0", c_req_ready, c_resp_valid, c_resp_rdata, c_resp_err);
    end
    reset = 1'b0;
    step;
  endtask

  task automatic test_store_load;
    a_txn("store_4", 1'b1, 32'h0000_0004, 32'h0000_0027, 32'h0, 1'b0, 0);
    a_txn("load_4",  1'b0, 32'h0000_0004, 32'h0, 32'h0000_0027, 1'b0, 0);
  endtask

  task automatic test_errors;
    a_txn("store_misaligned_6", 1'b1, 32'h0000_0006, 32'h0000_00FF, 32'h0, 1'b1, 0);
    a_txn("load_4_unchanged",   1'b0, 32'h0000_0004, 32'h0, 32'h0000_0027, 1'b0, 0);
    a_txn("load_oor_80",        1'b0, 32'h0000_0080, 32'h0, 32'h0, 1'b1, 0);
    a_txn("store_oor_80",       1'b1, 32'h0000_0080, 32'h0000_0077, 32'h0, 1'b1, 0);
  endtask

  task automatic test_boundary;
    a_txn("store_last_7c", 1'b1, 32'h0000_007C, 32'hA5A5_A5A5, 32'h0, 1'b0, 0);
    a_txn("load_last_7c",  1'b0, 32'h0000_007C, 32'h0, 32'hA5A5_A5A5, 1'b0, 0);
    // word 0 must be untouched by the busy-time noise and by the rejected 0x80 store
    a_txn("load_0_clean",  1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b0, 0);
  endtask

  task automatic test_back_pressure;
    a_txn("store_10",    1'b1, 32'h0000_0010, 32'h0000_0055, 32'h0, 1'b0, 0);
    a_txn("load_10_bp",  1'b0, 32'h0000_0010, 32'h0, 32'h0000_0055, 1'b0, 5);
  endtask

  task automatic test_reset_mid;
    b_txn("lat3_store_c", 1'b1, 32'h0000_000C, 32'h0000_0011, 32'h0, 1'b0);
    b_txn("lat3_load_c",  1'b0, 32'h0000_000C, 32'h0, 32'h0000_0011, 1'b0);
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h0000_0008; b_req_wdata = 32'h0000_0020;
    step;
    b_req_valid = 1'b0;
    step;
    n_tests++;
    if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_wait: valid=%b ready=%b want 0 0", b_resp_valid, b_req_ready);
    end
    // reset on the edge that would enter RESP, with a fresh request presented meanwhile
    reset = 1'b1;
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h0000_0008; b_req_wdata = 32'h0000_0099;
    step;
    n_tests++;
    if ({b_req_ready, b_resp_valid, b_resp_rdata, b_resp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL mid_reset: ready=%b valid=%b rdata=%h err=%b want 1 0 0 0", b_req_ready, b_resp_valid, b_resp_rdata, b_resp_err);
    end
    step;
    reset = 1'b0;
    b_req_valid = 1'b0;
    step;
    b_txn("lat3_load_8_after_reset", 1'b0, 32'h0000_0008, 32'h0, 32'h0, 1'b0);
    a_txn("lat2_load_4_after_reset", 1'b0, 32'h0000_0004, 32'h0, 32'h0000_0027, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] addr_t  [6] = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h0, 32'h0};
    logic [31:0] wdata_t [6] = '{32'h11, 32'h0, 32'h22, 32'h0, 32'h33, 32'h0};
    logic [31:0] exp_t   [6] = '{32'h0, 32'h11, 32'h0, 32'h22, 32'h0, 32'h33};
    c_req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      c_req_write = (i % 2 == 0);
      c_req_addr  = addr_t[i];
      c_req_wdata = wdata_t[i];
      n_tests++;
      if (c_req_ready !== 1'b1 || c_resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL b2b_idle%0d: ready=%b valid=%b want 1 0", i, c_req_ready, c_resp_valid);
      end
      step;
      n_tests++;
      if (c_resp_valid !== 1'b1 || c_resp_rdata !== exp_t[i] || c_resp_err !== 1'b0 || c_req_ready !== 1'b0) begin
        n_fail++; $display("FAIL b2b_resp%0d: valid=%b rdata=%h err=%b ready=%b want 1 %h 0 0",
                           i, c_resp_valid, c_resp_rdata, c_resp_err, c_req_ready, exp_t[i]);
      end
      step;
    end
    c_req_valid = 1'b0;
    n_tests++;
    if (c_req_ready !== 1'b1 || c_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: ready=%b valid=%b want 1 0", c_req_ready, c_resp_valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 32'h0; a_req_wdata = 32'h0; a_resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0; b_resp_ready = 1'b0;
    c_req_valid = 1'b0; c_req_write = 1'b0; c_req_addr = 32'h0; c_req_wdata = 32'h0;
    test_reset();
    test_store_load();
    test_errors();
    test_boundary();
    test_back_pressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter N, default 32: data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32: number of N-bit words stored.
REQ-003 SHALL have parameter LATENCY, default 2, legal range 1..15: cycles from request acceptance to the first response-valid cycle.
REQ-004 SHALL have port clock, input, 1: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1: initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1: responder can accept a request.
REQ-008 SHALL have port req_write, input, 1: 1 = store (sw), 0 = load (lw).
REQ-009 SHALL have port req_addr, input, 32: byte address.
REQ-010 SHALL have port req_wdata, input, N: store data.
REQ-011 SHALL have port resp_valid, output, 1: response available.
REQ-012 SHALL have port resp_ready, input, 1: initiator accepts the response.
REQ-013 SHALL have port resp_rdata, output, N: load data; 0 for stores and for errors.
REQ-014 SHALL have port resp_err, output, 1: request was misaligned or out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge where req_valid && req_ready.
REQ-017 SHALL capture req_write, req_addr and req_wdata at acceptance; later changes on the req_* inputs SHALL have no effect.
REQ-018 SHALL transition on acceptance to RESP when LATENCY=1, and otherwise to WAIT with a counter loaded with LATENCY-1.
REQ-019 SHALL decrement the counter each WAIT cycle and move to RESP on the edge where the counter reaches 1.
REQ-020 SHALL assert resp_valid exactly LATENCY cycles after the acceptance edge, and hold resp_valid, resp_rdata and resp_err stable until resp_valid && resp_ready.
REQ-021 SHALL return to IDLE on the response-handshake edge; the next request can be accepted no earlier than the following edge.
REQ-022 SHALL complete the response handshake in the first RESP cycle if resp_ready is already high.
REQ-023 SHALL compute the word index as addr[31:2], flag misalignment when addr[1:0] != 0, and flag out-of-range when the index >= DEPTH.
REQ-024 SHALL, for a valid store, write the word on the edge entering RESP and drive resp_rdata = 0 and resp_err = 0.
REQ-025 SHALL, for a valid load, register mem[index] on the edge entering RESP and drive resp_err = 0.
REQ-026 SHALL, for an errored request, leave memory unmodified and drive resp_rdata = 0 and resp_err = 1.
REQ-027 SHALL make a load that follows a store to the same word return the stored value.
REQ-028 SHALL initialise every memory word to 0 at time zero.
REQ-029 SHALL ignore req_valid while in WAIT or RESP, with no queuing.

Reset
REQ-030 SHALL, while reset is high at an edge, enter IDLE, clear the counter, and drive req_ready=1, resp_valid=0, resp_rdata=0 and resp_err=0 on the next cycle.
REQ-031 SHALL discard an in-flight store when reset is asserted during WAIT, leaving the memory word unmodified.
REQ-032 SHALL leave memory contents unaffected by reset.
REQ-033 SHALL ignore req_valid during any cycle in which reset is high.

Verification
REQ-034 SHALL cover a store then a load (LATENCY=2): store addr 0x4 data 0x27, then load 0x4 -> each resp_valid rises 2 cycles after acceptance; load resp_rdata=0x27, resp_err=0.
REQ-035 SHALL cover a misaligned store: store addr 0x6 data 0xFF -> resp_err=1, resp_rdata=0; a subsequent load of 0x4 still returns the prior value.
REQ-036 SHALL cover an out-of-range load: load addr 0x80 with DEPTH=32 -> resp_err=1, resp_rdata=0.
REQ-037 SHALL cover back-pressure: hold resp_ready=0 for 5 cycles after resp_valid rises -> resp_valid and data held stable; req_ready stays 0 until the handshake, then returns to 1 on the next cycle.
REQ-038 SHALL cover reset mid-operation: store addr 0x8 data 0x20, assert reset in WAIT (LATENCY=3) -> req_ready=1, resp_valid=0; a later load of 0x8 returns 0.
REQ-039 SHALL cover LATENCY=1 with resp_ready tied high: alternating store/load -> one transaction every 2 cycles, resp_valid high for 1 cycle each.
